// File: rtl/bus_to_uart_pkg.sv
// Shared definitions for the internal serial bus slaves and the UART return path.
package bus_to_uart_pkg;

   // Default serial frame geometry: 14 address bits, last 8 cycles also carry data.
   localparam int ADDR_W_DEF  = 14;
   localparam int DATA_W_DEF  = 8;
   localparam int MATCH_W_DEF = 2;

   // Slave select encodings found in addr[ADDR_W-1 -: MATCH_W].
   localparam logic [1:0] SLAVE_ID_S0   = 2'b00;
   localparam logic [1:0] SLAVE_ID_UART = 2'b01;
   localparam logic [1:0] SLAVE_ID_S2   = 2'b10;
   localparam logic [1:0] SLAVE_ID_S3   = 2'b11;

   // UART line level when nothing is being sent (also the stop bit level).
   localparam logic UART_IDLE = 1'b1;

   typedef enum logic [1:0] {
      CAP_IDLE   = 2'd0,
      CAP_SHIFT  = 2'd1,
      CAP_COMMIT = 2'd2
   } cap_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/bus_to_uart_fifo.sv
// Small first-word-fall-through byte FIFO; the head entry is always visible on rd_data.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              do_push;
   logic              do_pop;

   // Guard against pushing into a full FIFO or popping an empty one.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rd_data = mem_reg[rd_ptr_reg];

   // Storage array: written only, never reset, so it maps onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH; simultaneous push and pop keep the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/bus_to_uart.sv
// Serial bus write slave feeding a byte FIFO that drains onto an 8N1 UART TX line.
module bus_to_uart
   import bus_to_uart_pkg::*;
#(
   parameter int               ADDR_W     = ADDR_W_DEF,
   parameter int               DATA_W     = DATA_W_DEF,
   parameter int               MATCH_W    = MATCH_W_DEF,
   parameter logic [MATCH_W-1:0] SLAVE_ID = SLAVE_ID_UART,
   parameter int               FIFO_DEPTH = 4,
   localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             valid_s,
   input  logic             write_en_slave,
   input  logic             bus_addr_in,
   input  logic             bus_data_in,
   output logic             slave_ready,
   output logic             uart_tx,
   output logic             tx_busy,
   output logic             overflow,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int BIT_W      = $clog2(ADDR_W);
   localparam int TXB_W      = $clog2(DATA_W);
   localparam int DATA_START = ADDR_W - DATA_W;

   cap_state_t         cap_state_reg;
   logic [BIT_W-1:0]   bit_cnt_reg;
   logic [ADDR_W-1:0]  addr_sr_reg;
   logic [DATA_W-1:0]  data_sr_reg;
   logic               overflow_reg;

   tx_state_t          tx_state_reg;
   logic [DATA_W-1:0]  tx_shift_reg;
   logic [TXB_W-1:0]   tx_bit_reg;
   logic               uart_tx_reg;
   logic               tx_busy_reg;

   logic               addr_match;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [DATA_W-1:0]  fifo_rd_data;

   assign addr_match = (addr_sr_reg[ADDR_W-1 -: MATCH_W] == SLAVE_ID);
   assign fifo_push  = (cap_state_reg == CAP_COMMIT) && addr_match && !fifo_full;
   // A byte leaves the FIFO exactly when a start bit is launched.
   assign fifo_pop   = tick && !fifo_empty &&
                       ((tx_state_reg == TX_IDLE) || (tx_state_reg == TX_STOP));

   assign slave_ready = !fifo_full;
   assign uart_tx     = uart_tx_reg;
   assign tx_busy     = tx_busy_reg;
   assign overflow    = overflow_reg;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (data_sr_reg),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Capture FSM: deserialise a write frame, stall while valid_s is low, then commit once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_state_reg <= CAP_IDLE;
         bit_cnt_reg   <= '0;
         addr_sr_reg   <= '0;
         data_sr_reg   <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         case (cap_state_reg)
            CAP_IDLE: begin
               if (valid_s && !write_en_slave) begin
                  addr_sr_reg   <= {{(ADDR_W-1){1'b0}}, bus_addr_in};
                  data_sr_reg   <= '0;
                  bit_cnt_reg   <= BIT_W'(1);
                  cap_state_reg <= CAP_SHIFT;
               end
            end
            CAP_SHIFT: begin
               if (valid_s) begin
                  addr_sr_reg <= {addr_sr_reg[ADDR_W-2:0], bus_addr_in};
                  if (bit_cnt_reg >= BIT_W'(DATA_START)) begin
                     data_sr_reg <= {data_sr_reg[DATA_W-2:0], bus_data_in};
                  end
                  if (bit_cnt_reg == BIT_W'(ADDR_W-1)) begin
                     cap_state_reg <= CAP_COMMIT;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
            end
            CAP_COMMIT: begin
               // The push itself is decoded combinationally from this state.
               if (addr_match && fifo_full) begin
                  overflow_reg <= 1'b1;
               end
               bit_cnt_reg   <= '0;
               cap_state_reg <= CAP_IDLE;
            end
            default: cap_state_reg <= CAP_IDLE;
         endcase
      end
   end

   // TX FSM: one line bit per tick; a stop bit flows straight into the next start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_reg <= TX_IDLE;
         tx_shift_reg <= '0;
         tx_bit_reg   <= '0;
         uart_tx_reg  <= UART_IDLE;
         tx_busy_reg  <= 1'b0;
      end else if (tick) begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (!fifo_empty) begin
                  tx_shift_reg <= fifo_rd_data;
                  uart_tx_reg  <= 1'b0;
                  tx_busy_reg  <= 1'b1;
                  tx_state_reg <= TX_START;
               end
            end
            TX_START: begin
               uart_tx_reg  <= tx_shift_reg[0];
               tx_shift_reg <= tx_shift_reg >> 1;
               tx_bit_reg   <= '0;
               tx_state_reg <= TX_DATA;
            end
            TX_DATA: begin
               // tx_bit_reg is the index of the data bit currently on the line.
               if (tx_bit_reg == TXB_W'(DATA_W-1)) begin
                  uart_tx_reg  <= UART_IDLE;
                  tx_state_reg <= TX_STOP;
               end else begin
                  uart_tx_reg  <= tx_shift_reg[0];
                  tx_shift_reg <= tx_shift_reg >> 1;
                  tx_bit_reg   <= tx_bit_reg + 1'b1;
               end
            end
            TX_STOP: begin
               if (!fifo_empty) begin
                  tx_shift_reg <= fifo_rd_data;
                  uart_tx_reg  <= 1'b0;
                  tx_state_reg <= TX_START;
               end else begin
                  uart_tx_reg  <= UART_IDLE;
                  tx_busy_reg  <= 1'b0;
                  tx_state_reg <= TX_IDLE;
               end
            end
            default: tx_state_reg <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_to_uart.sv
// Self-checking bench: frames are driven serially, expected bytes queued, a UART receiver pops them.
module tb_bus_to_uart;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       valid_s;
   logic       write_en_slave;
   logic       bus_addr_in;
   logic       bus_data_in;
   logic       slave_ready;
   logic       uart_tx;
   logic       tx_busy;
   logic       overflow;
   logic [2:0] fifo_count;

   int         checks;
   int         failures;
   logic [7:0] exp_q [$];
   int         model_count;
   logic       exp_ovf;
   int         tick_period;
   bit         tick_req;
   int         tick_total;
   int         tick_phase;
   int         rx_idx;
   logic [7:0] rx_byte;
   int         chars_seen;

   bus_to_uart dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .valid_s        (valid_s),
      .write_en_slave (write_en_slave),
      .bus_addr_in    (bus_addr_in),
      .bus_data_in    (bus_data_in),
      .slave_ready    (slave_ready),
      .uart_tx        (uart_tx),
      .tx_busy        (tx_busy),
      .overflow       (overflow),
      .fifo_count     (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Baud strobe: periodic when tick_period > 0, or a single requested pulse.
   initial begin
      tick       = 1'b0;
      tick_req   = 1'b0;
      tick_total = 0;
      tick_phase = 0;
      forever begin
         @(posedge clk);
         #2;
         if (tick_req) begin
            tick     = 1'b1;
            tick_req = 1'b0;
         end else if (tick_period > 0) begin
            if (tick_phase >= tick_period - 1) begin
               tick       = 1'b1;
               tick_phase = 0;
            end else begin
               tick       = 1'b0;
               tick_phase++;
            end
         end else begin
            tick = 1'b0;
         end
         if (tick) tick_total++;
      end
   end

   // UART receiver: samples the line once after every tick and checks against the scoreboard.
   initial begin
      rx_idx     = -1;
      rx_byte    = '0;
      chars_seen = 0;
      forever begin
         @(posedge clk);
         if (!reset) begin
            rx_idx = -1;
         end else if (tick) begin
            #3;
            if (rx_idx < 0) begin
               if (uart_tx == 1'b0) begin
                  rx_idx  = 0;
                  rx_byte = '0;
                  model_count--;
               end
            end else if (rx_idx < 8) begin
               rx_byte[rx_idx] = uart_tx;
               rx_idx++;
            end else begin
               chk("stop_bit", uart_tx, 1);
               if (exp_q.size() == 0) chk("char_unexpected", exp_q.size(), 1);
               else                   chk("char_data", rx_byte, exp_q.pop_front());
               $display("char %0d received %02h", chars_seen, rx_byte);
               chars_seen++;
               rx_idx = -1;
            end
         end
      end
   end

   task automatic send_frame(input logic [13:0] addr, input logic [7:0] data, input logic we,
                             input int stall_at, input bit tick_commit);
      bit match;
      bit acc;
      int j;
      match = (addr[13:12] == 2'b01);
      acc   = !we && match && (model_count < 4);
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         j              = 13 - i;
         valid_s        = 1'b1;
         write_en_slave = we;
         bus_addr_in    = addr[j];
         bus_data_in    = (i >= 6) ? data[j] : 1'b0;
         if (i == stall_at) begin
            for (int s = 0; s < 5; s++) begin
               @(posedge clk);
               #1;
               valid_s     = 1'b0;
               bus_addr_in = 1'($urandom);
               bus_data_in = 1'($urandom);
            end
         end
      end
      @(posedge clk);
      #1;
      valid_s = 1'b0;
      if (tick_commit) tick_req = 1'b1;
      if (acc) begin
         exp_q.push_back(data);
         model_count++;
      end
      if (!we && match && !acc) exp_ovf = 1'b1;
      @(posedge clk);
      #6;
      $display("frame addr=%04h data=%02h we=%0b count=%0d ready=%0b ovf=%0b",
               addr, data, we, fifo_count, slave_ready, overflow);
      chk("fifo_count", fifo_count, model_count);
      chk("slave_ready", slave_ready, (model_count < 4));
      chk("overflow", overflow, exp_ovf);
   endtask

   task automatic wait_busy(input logic lvl, input int max_cyc, input string tag);
      int n;
      n = 0;
      while (tx_busy !== lvl && n < max_cyc) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (tx_busy !== lvl) chk(tag, tx_busy, lvl);
   endtask

   // Run ticks until the transmitter goes idle and check how many tick periods it stayed busy.
   task automatic drain(input int period, input int exp_ticks, input string tag);
      int t0;
      @(posedge clk);
      #1;
      tick_period = period;
      wait_busy(1'b1, 200, "busy_rise_timeout");
      t0 = tick_total;
      wait_busy(1'b0, 2000, "busy_fall_timeout");
      chk(tag, tick_total - t0, exp_ticks);
      tick_period = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", exp_q.size(), 0);
      chk("uart_idle_after", uart_tx, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int n;
      checks         = 0;
      failures       = 0;
      model_count    = 0;
      exp_ovf        = 1'b0;
      tick_period    = 0;
      reset          = 1'b0;
      valid_s        = 1'b0;
      write_en_slave = 1'b0;
      bus_addr_in    = 1'b0;
      bus_data_in    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_ready", slave_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_count", fifo_count, 0);
      reset = 1'b1;

      // 1: single matching frame, A5 on the line, busy for 10 tick periods
      send_frame(14'b01_000000000000, 8'hA5, 1'b0, -1, 1'b0);
      drain(3, 10, "t1_busy_ticks");

      // 2: same frame with a 5-cycle stall after bit 3
      send_frame(14'b01_000000000000, 8'hA5, 1'b0, 3, 1'b0);
      drain(2, 10, "t2_busy_ticks");

      // 3: non-matching slave select, nothing pushed or sent
      send_frame(14'b10_000000000000, 8'h5A, 1'b0, -1, 1'b0);
      tick_period = 2;
      lows = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (uart_tx !== 1'b1) lows++;
      end
      tick_period = 0;
      chk("t3_line_low_cycles", lows, 0);
      chk("t3_busy", tx_busy, 0);

      // 4: six frames with the transmitter stalled; last two dropped, then back-to-back drain
      for (int k = 1; k <= 6; k++) begin
         send_frame(14'b01_000000000000, 8'(k), 1'b0, -1, 1'b0);
      end
      drain(2, 40, "t4_busy_ticks");
      chk("t4_ready_after", slave_ready, 1);
      chk("t4_overflow_sticky", overflow, 1);

      // 5: read frame ignored; push and pop in the same cycle at count 2
      send_frame(14'b01_000000000000, 8'hEE, 1'b1, -1, 1'b0);
      send_frame(14'b01_000000000000, 8'h11, 1'b0, -1, 1'b0);
      send_frame(14'b01_000000000000, 8'h22, 1'b0, -1, 1'b0);
      send_frame(14'b01_000000000000, 8'h33, 1'b0, -1, 1'b1);
      chk("t5_busy_after_pop", tx_busy, 1);
      tick_period = 2;
      wait_busy(1'b0, 2000, "t5_busy_fall_timeout");
      tick_period = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("t5_sb_empty", exp_q.size(), 0);

      // 6: reset during data bit 3 of a character with another byte queued
      send_frame(14'b01_000000000000, 8'h3C, 1'b0, -1, 1'b0);
      send_frame(14'b01_000000000000, 8'h77, 1'b0, -1, 1'b0);
      tick_period = 2;
      n = 0;
      while (rx_idx != 4 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t6_reached_bit3", rx_idx, 4);
      reset = 1'b0;
      #1;
      chk("t6_uart_tx", uart_tx, 1);
      chk("t6_busy", tx_busy, 0);
      chk("t6_count", fifo_count, 0);
      chk("t6_ready", slave_ready, 1);
      chk("t6_overflow", overflow, 0);
      exp_q.delete();
      model_count = 0;
      exp_ovf     = 1'b0;
      tick_period = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Recovery after reset: a fresh frame goes through cleanly
      send_frame(14'b01_000000000000, 8'hC3, 1'b0, -1, 1'b0);
      drain(2, 10, "t6_recover_busy_ticks");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
